wb_mem_arbiter: RTL and testbench

//  Two-master round-robin Wishbone (pipelined) arbiter sharing one backing-memory port between the

---
 rtl/wb_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone (pipelined) arbiter.
// M0 = data cache, M1 = instruction cache. Grant is held for a whole cyc burst;
// a bus watchdog aborts a granted burst that sees no ack/err for TIMEOUT cycles.
//
// state | meaning
// IDLE  | no owner, both masters stalled, slave bus quiet
// GNT0  | M0 owns the slave port until it drops cyc (or watchdog abort)
// GNT1  | M1 owns the slave port until it drops cyc (or watchdog abort)
module wb_mem_arbiter #(
    parameter int AW      = 12,
    parameter int TIMEOUT = 255
) (
    input  logic          cpu_clock_i,
    input  logic          cpu_reset_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_stall_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_stall_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_stall_i,
    input  logic [31:0]   s_dat_i,
    output logic [1:0]    grant_o
);

    // Counter is at least 8 bits so small TIMEOUT values still saturate cleanly.
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_owner_q, last_owner_d;   // 0 = M0, 1 = M1
    logic [WDW-1:0] wd_q, wd_d;
    logic           own_cyc;
    logic           wd_abort;

    // Read data is broadcast; masters only trust it when acked.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Owner's cyc and watchdog expiry; a same-cycle ack/err beats the abort.
    always_comb begin
        own_cyc  = 1'b0;
        wd_abort = 1'b0;
        case (state_q)
            GNT0:    own_cyc = m0_cyc_i;
            GNT1:    own_cyc = m1_cyc_i;
            default: own_cyc = 1'b0;
        endcase
        if (TIMEOUT != 0) begin
            wd_abort = own_cyc && (wd_q == WDW'(TIMEOUT)) && !s_ack_i && !s_err_i;
        end
    end

    // Next-state: round-robin on ties, release on cyc low, abort back to IDLE.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (wd_abort) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end else if (!m0_cyc_i) begin
                    last_owner_d = 1'b0;
                    state_d      = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (wd_abort) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end else if (!m1_cyc_i) begin
                    last_owner_d = 1'b1;
                    state_d      = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog: cleared by any response or grant change, saturating count otherwise.
    always_comb begin
        wd_d = wd_q;
        if ((TIMEOUT == 0) || (state_d != state_q) || s_ack_i || s_err_i) begin
            wd_d = '0;
        end else if (own_cyc && (wd_q != '1)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Bus routing from the registered grant; responses gated by the owner's cyc.
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;
        grant_o    = 2'b00;
        case (state_q)
            GNT0: begin
                grant_o    = 2'b01;
                s_cyc_o    = m0_cyc_i & ~wd_abort;
                s_stb_o    = m0_stb_i & ~wd_abort;
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_sel_o    = m0_sel_i;
                m0_stall_o = s_stall_i;
                m0_ack_o   = s_ack_i & m0_cyc_i;
                m0_err_o   = (s_err_i & m0_cyc_i) | wd_abort;
            end
            GNT1: begin
                grant_o    = 2'b10;
                s_cyc_o    = m1_cyc_i & ~wd_abort;
                s_stb_o    = m1_stb_i & ~wd_abort;
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_sel_o    = m1_sel_i;
                m1_stall_o = s_stall_i;
                m1_ack_o   = s_ack_i & m1_cyc_i;
                m1_err_o   = (s_err_i & m1_cyc_i) | wd_abort;
            end
            default: ;
        endcase
    end

    // State, round-robin pointer and watchdog registers.
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            wd_q         <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: two bus-functional masters, a one-cycle-ack slave,
// and scoreboards for read data (per master) and forwarded write beats.
module tb_wb_mem_arbiter;

    localparam int AW = 12;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [AW-1:0] m0_adr_i = '0;
    logic [31:0]   m0_dat_i = '0;
    logic [3:0]    m0_sel_i = '0;
    logic [31:0]   m0_dat_o;
    logic          m0_ack_o, m0_err_o, m0_stall_o;
    logic          m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [AW-1:0] m1_adr_i = '0;
    logic [31:0]   m1_dat_i = '0;
    logic [3:0]    m1_sel_i = '0;
    logic [31:0]   m1_dat_o;
    logic          m1_ack_o, m1_err_o, m1_stall_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_ack_i = 0, s_err_i = 0, s_stall_i = 0;
    logic [31:0]   s_dat_i = '0;
    logic [1:0]    grant_o;

    wb_mem_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
        .cpu_clock_i(clk), .cpu_reset_i(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // master model state
    bit            act [2];
    int            nb [2], iss [2], ackc [2], errc [2];
    logic [AW-1:0] base [2];
    bit            wr [2];
    logic [32:0]   exq [2][$];     // {is_write, expected read data}
    logic [47:0]   wq [$];         // {adr, sel, data} expected at the slave
    // slave model state
    bit            ack_en = 1'b1;
    int            stall_left = 0;
    bit            pend_ack = 1'b0;
    logic [31:0]   pend_dat = '0;
    bit            stray = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] wdat(input int i, input logic [AW-1:0] a);
        return 32'hB000_0000 | (32'(i) << 20) | 32'(a);
    endfunction

    task automatic start(input int i, input logic [AW-1:0] b, input int n, input bit w);
        act[i] = 1; nb[i] = n; iss[i] = 0; ackc[i] = 0; errc[i] = 0; base[i] = b; wr[i] = w;
    endtask

    task automatic service(input int i, input logic stb, input logic stall, input logic ack,
                           input logic err, input logic [31:0] dat, input logic [AW-1:0] adr);
        logic [32:0] e;
        if (ack) begin
            chk($sformatf("m%0d_ack_expected", i), exq[i].size() != 0, 1);
            if (exq[i].size() != 0) begin
                e = exq[i].pop_front();
                if (!e[32]) chk($sformatf("m%0d_rdata", i), dat, e[31:0]);
                ackc[i]++;
            end
        end
        if (err) begin
            errc[i]++;
            exq[i].delete();
            act[i] = 0;
        end else if (stb && !stall) begin
            exq[i].push_back({wr[i], wr[i] ? 32'h0 : memfn(adr)});
            if (wr[i]) wq.push_back({adr, 4'hF, wdat(i, adr)});
            iss[i]++;
        end
        if (act[i] && ackc[i] == nb[i]) act[i] = 0;
    endtask

    // One bus cycle: drive at negedge, sample settled outputs 1 ns later.
    task automatic tick();
        logic [1:0] g;
        @(negedge clk);
        m0_cyc_i = act[0]; m0_stb_i = act[0] && (iss[0] < nb[0]); m0_we_i = wr[0];
        m0_adr_i = base[0] + AW'(iss[0]); m0_dat_i = wdat(0, m0_adr_i); m0_sel_i = 4'hF;
        m1_cyc_i = act[1]; m1_stb_i = act[1] && (iss[1] < nb[1]); m1_we_i = wr[1];
        m1_adr_i = base[1] + AW'(iss[1]); m1_dat_i = wdat(1, m1_adr_i); m1_sel_i = 4'hF;
        s_ack_i = (pend_ack && ack_en) || stray;
        s_dat_i = pend_dat;
        s_stall_i = (stall_left > 0);
        s_err_i = 1'b0;
        #1;
        g = grant_o;
        chk("gnt_legal", grant_o == 2'b11, 0);
        if (g == 2'b00) chk("idle_scyc", s_cyc_o, 0);
        if (!g[0]) begin
            chk("m0_stall_ng", m0_stall_o, 1); chk("m0_ack_ng", m0_ack_o, 0); chk("m0_err_ng", m0_err_o, 0);
        end
        if (!g[1]) begin
            chk("m1_stall_ng", m1_stall_o, 1); chk("m1_ack_ng", m1_ack_o, 0); chk("m1_err_ng", m1_err_o, 0);
        end
        if (g[0]) chk("route_adr0", s_adr_o, m0_adr_i);
        if (g[1]) chk("route_adr1", s_adr_o, m1_adr_i);
        service(0, m0_stb_i, m0_stall_o, m0_ack_o, m0_err_o, m0_dat_o, m0_adr_i);
        service(1, m1_stb_i, m1_stall_o, m1_ack_o, m1_err_o, m1_dat_o, m1_adr_i);
        if (s_cyc_o && s_stb_o && !s_stall_i) begin
            pend_ack = 1'b1;
            pend_dat = memfn(s_adr_o);
            if (s_we_o) begin
                chk("wr_q_nonempty", wq.size() != 0, 1);
                if (wq.size() != 0) chk("wr_beat", {s_adr_o, s_sel_o, s_dat_o}, wq.pop_front());
            end
        end else begin
            pend_ack = 1'b0;
        end
        if (stall_left > 0 && s_stb_o) stall_left--;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; nb[i] = 0; iss[i] = 0; ackc[i] = 0; errc[i] = 0; base[i] = '0; wr[i] = 0;
            exq[i].delete();
        end
        wq.delete();
        pend_ack = 0; stall_left = 0; ack_en = 1; stray = 0;
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i = 0; s_stall_i = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int i);
        int k = 0;
        while (act[i] && k < 40) begin
            tick();
            k++;
        end
        chk($sformatf("m%0d_done", i), act[i], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        @(negedge clk); #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_scyc", s_cyc_o, 0);
        chk("rst_sstb", s_stb_o, 0);
        chk("rst_sadr", s_adr_o, 0);
        chk("rst_ssel", s_sel_o, 0);
        chk("rst_m0stall", m0_stall_o, 1);
        chk("rst_m1stall", m1_stall_o, 1);
        do_reset();

        // reset asserted in the middle of a GNT0 burst
        start(0, 12'h020, 4, 0);
        stall_left = 100;
        tick(); tick();
        chk("t1_gnt0", grant_o, 2'b01);
        chk("t1_scyc_pre", s_cyc_o, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_rst_grant", grant_o, 2'b00);
        chk("t1_rst_scyc", s_cyc_o, 0);
        chk("t1_rst_m0stall", m0_stall_o, 1);
        chk("t1_rst_m1stall", m1_stall_o, 1);
        chk("t1_rst_m0ack", m0_ack_o, 0);
        do_reset();

        // M0 4-word fill alone
        start(0, 12'h010, 4, 0);
        tick();
        chk("t2_lat_grant", grant_o, 2'b00);
        chk("t2_lat_scyc", s_cyc_o, 0);
        tick();
        chk("t2_grant", grant_o, 2'b01);
        chk("t2_scyc", s_cyc_o, 1);
        chk("t2_adr0", s_adr_o, 12'h010);
        run_until_done(0);
        chk("t2_m0_acks", ackc[0], 4);
        chk("t2_m1_acks", ackc[1], 0);
        tick(); tick();
        chk("t2_idle", grant_o, 2'b00);

        // simultaneous request from reset, zero-idle handover
        do_reset();
        start(0, 12'h100, 2, 0);
        start(1, 12'h200, 2, 0);
        tick();
        chk("t3_first_idle", grant_o, 2'b00);
        tick();
        chk("t3_m0_first", grant_o, 2'b01);
        run_until_done(0);
        tick();
        chk("t3_drop_grant", grant_o, 2'b01);
        chk("t3_drop_scyc", s_cyc_o, 0);
        tick();
        chk("t3_handover", grant_o, 2'b10);
        run_until_done(1);
        chk("t3_m1_acks", ackc[1], 2);
        tick(); tick();
        chk("t3_idle", grant_o, 2'b00);

        // M0 re-requests after release while M1 waits: M1 goes first
        start(0, 12'h140, 2, 0);
        start(1, 12'h240, 2, 0);
        tick();
        tick();
        chk("t4_m0_first", grant_o, 2'b01);
        run_until_done(0);
        tick();
        start(0, 12'h300, 2, 0);
        tick();
        chk("t4_rr_m1", grant_o, 2'b10);
        chk("t4_m0_stalled", m0_stall_o, 1);
        run_until_done(1);
        tick();
        tick();
        chk("t4_back_m0", grant_o, 2'b01);
        run_until_done(0);
        chk("t4_m0_acks", ackc[0], 2);
        chk("t4_m1_acks", ackc[1], 2);
        tick(); tick();
        chk("t4_idle", grant_o, 2'b00);

        // watchdog abort on an M1 read the slave never answers
        ack_en = 1'b0;
        start(1, 12'h055, 1, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("t5_err_k%0d", k), m1_err_o, (k == 8) ? 1'b1 : 1'b0);
            chk($sformatf("t5_grant_k%0d", k), grant_o, (k <= 8) ? 2'b10 : 2'b00);
            if (k == 8) chk("t5_abort_scyc", s_cyc_o, 0);
        end
        chk("t5_err_count", errc[1], 1);
        chk("t5_m1_acks", ackc[1], 0);
        ack_en = 1'b1;

        // stray ack in IDLE, then a stalled M0 write
        stray = 1'b1;
        tick();
        chk("t6_stray_m0ack", m0_ack_o, 0);
        chk("t6_stray_m1ack", m1_ack_o, 0);
        stray = 1'b0;
        start(0, 12'h0A5, 1, 1);
        stall_left = 2;
        tick();
        tick();
        chk("t6_grant", grant_o, 2'b01);
        chk("t6_stb_held0", s_stb_o, 1);
        chk("t6_we", s_we_o, 1);
        chk("t6_m0stall0", m0_stall_o, 1);
        tick();
        chk("t6_stb_held1", s_stb_o, 1);
        chk("t6_adr_held1", s_adr_o, 12'h0A5);
        chk("t6_m0stall1", m0_stall_o, 1);
        run_until_done(0);
        chk("t6_m0_acks", ackc[0], 1);
        chk("t6_wq_empty", wq.size(), 0);
        tick(); tick();
        chk("t6_idle", grant_o, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
